spi_frame_transmitter: RTL and testbench
========================================

Name: spi_frame_transmitter

Overview:
- SPI master, transmit-only, mode 0, MSB first. Serialises one note-parameter frame toward the keyboard's SPI receive path.
- Frame contents: three 32-bit note periods plus a control word carrying waveform and note count.
- Sits on the controller side of the link. Produces sck/sdo from the system clock.
- The first frame after reset is preceded by a 32-bit sync word, which the receiver uses to start its bit counter.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period (>=1); one bit occupies 2*CLK_DIV clk cycles.
- SYNC_WORD, 32'h0000_FFFF, word sent once before the first frame after reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- valid  input  1  request to send a frame; accepted when valid && ready.
- prd1  input  32  note 1 period, in clk cycles.
- prd2  input  32  note 2 period.
- prd3  input  32  note 3 period.
- waveform  input  2  00 square, 01 sawtooth, 10 triangle, 11 sine.
- notes  input  2  number of active notes (1..3).
- ready  output  1  high in IDLE only.
- busy  output  1  high from acceptance until the final bit's falling edge.
- done  output  1  one-cycle pulse at frame end.
- sck  output  1  serial clock; idles low.
- sdo  output  1  serial data.

Behaviour:
- Reset values (asynchronous, held while reset_n low):
  - sck=0, sdo=0, ready=1, busy=0, done=0.
  - State=IDLE; synced flag=0; all shadow registers and counters 0.
- Acceptance:
  - On posedge clk with valid && ready, latch prd1/prd2/prd3 and the control word into shadow registers.
  - Control word = {28'b0, notes, waveform}.
  - Input changes after acceptance have no effect on the frame in flight.
  - valid while busy is ignored; there is no queueing.
- States:
  - IDLE -> SYNC on acceptance if synced=0; IDLE -> DATA on acceptance if synced=1.
  - SYNC -> DATA after 32 bits; synced is set at this transition.
  - DATA runs word index 0..3 (prd1, prd2, prd3, control), 32 bits each, 128 bits total, no gaps between words.
  - DATA -> DONE after the last bit; DONE -> IDLE after one cycle.
- Bit timing:
  - In the acceptance cycle, sdo takes the MSB of the first word (SYNC_WORD[31] or prd1[31]).
  - sck stays low for CLK_DIV cycles, goes high for CLK_DIV cycles, then falls.
  - sdo updates to the next bit in the same cycle as each sck falling edge, so sdo is stable across every rising edge.
  - The bit counter advances on each falling edge.
  - The half-period counter runs 0..CLK_DIV-1 and wraps.
- Frame end:
  - After the 128th data bit's falling edge, sck=0 and sdo=0.
  - busy drops and done pulses high for exactly one cycle (DONE state).
  - ready returns high the following cycle, so back-to-back frames have a 2-cycle minimum gap.
- Frame duration:
  - First frame after reset: 160 bits * 2*CLK_DIV cycles.
  - Later frames: 128 bits * 2*CLK_DIV cycles.
  - Exact sck rising-edge count is 160 and 128 respectively.
- Reset mid-frame: everything returns to reset values immediately, including synced=0, so the next frame resends SYNC_WORD.
- No wait states and no back-pressure on the serial side.
- sck is a registered output, glitch-free.

Test Plan:
1. Reset release, valid=1 once with prd1=32'h0001_2345, prd2=32'h0000_ABCD, prd3=32'h0000_0F0F, waveform=2'b11, notes=2'b11, CLK_DIV=2:
   - Sampling sdo on sck rising edges yields 0x0000FFFF, 0x00012345, 0x0000ABCD, 0x00000F0F, 0x0000000F.
   - Exactly 160 rising edges.
   - done pulses once, 640 cycles after acceptance.
2. Second frame immediately after done, prd1=32'hDEADBEEF, others 0, waveform=01, notes=01:
   - No sync word.
   - Words are 0xDEADBEEF, 0, 0, 0x00000005.
   - 128 rising edges; frame takes 512 cycles.
3. Hold valid high and toggle prd1 and waveform during a frame:
   - ready=0 throughout; the captured words equal the values at acceptance.
   - A new frame starts only after ready returns high.
4. Assert reset_n=0 at bit 70 of a frame:
   - sck and sdo go to 0 immediately; busy=0, ready=1.
   - The next accepted frame begins with 0x0000FFFF.
5. CLK_DIV=1:
   - sck period is 2 clk cycles.
   - sdo changes only in cycles where sck falls, never where sck rises; checked by assertion over a full frame.
6. Idle check with valid=0 for 1000 cycles after reset:
   - sck=0, sdo=0, busy=0, done never asserted.

Source files
------------

// File: rtl/spi_frame_transmitter.sv
// Transmit-only SPI master (mode 0, MSB first) sending one note-parameter frame:
// prd1, prd2, prd3 and a control word. The first frame after reset is preceded by SYNC_WORD.
module spi_frame_transmitter #(
    parameter int          CLK_DIV   = 4,
    parameter logic [31:0] SYNC_WORD = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [31:0] prd1,
    input  logic [31:0] prd2,
    input  logic [31:0] prd3,
    input  logic [1:0]  waveform,
    input  logic [1:0]  notes,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        sck,
    output logic        sdo
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        synced_q, synced_d;
    logic [31:0] prd1_q, prd1_d;
    logic [31:0] prd2_q, prd2_d;
    logic [31:0] prd3_q, prd3_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [4:0]  bit_q, bit_d;
    logic [1:0]  word_q, word_d;
    logic [HW-1:0] half_q, half_d;
    logic        sck_q, sck_d;
    logic        sdo_q, sdo_d;

    logic [31:0] cur_word;
    logic [31:0] nxt_word;
    logic        half_last;

    assign half_last = (half_q == HW'(CLK_DIV - 1));

    // Word being shifted now, and the word that follows it on the wire
    always_comb begin
        cur_word = SYNC_WORD;
        nxt_word = prd1_q;
        if (state_q == DATA) begin
            case (word_q)
                2'd0:    begin cur_word = prd1_q; nxt_word = prd2_q; end
                2'd1:    begin cur_word = prd2_q; nxt_word = prd3_q; end
                2'd2:    begin cur_word = prd3_q; nxt_word = ctrl_q; end
                default: begin cur_word = ctrl_q; nxt_word = 32'd0;  end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        synced_d = synced_q;
        prd1_d   = prd1_q;
        prd2_d   = prd2_q;
        prd3_d   = prd3_q;
        ctrl_d   = ctrl_q;
        bit_d    = bit_q;
        word_d   = word_q;
        half_d   = half_q;
        sck_d    = sck_q;
        sdo_d    = sdo_q;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    prd1_d  = prd1;
                    prd2_d  = prd2;
                    prd3_d  = prd3;
                    ctrl_d  = {28'b0, notes, waveform};
                    bit_d   = 5'd0;
                    word_d  = 2'd0;
                    half_d  = '0;
                    sck_d   = 1'b0;
                    sdo_d   = synced_q ? prd1[31] : SYNC_WORD[31];
                    state_d = synced_q ? DATA : SYNC;
                end
            end
            SYNC, DATA: begin
                if (!half_last) begin
                    half_d = half_q + HW'(1);
                end else begin
                    half_d = '0;
                    sck_d  = ~sck_q;
                    // Falling edge: move sdo to the next bit so it is stable at the next rise
                    if (sck_q) begin
                        if (bit_q != 5'd31) begin
                            bit_d = bit_q + 5'd1;
                            sdo_d = cur_word[5'd30 - bit_q];
                        end else begin
                            bit_d = 5'd0;
                            if (state_q == SYNC) begin
                                state_d  = DATA;
                                synced_d = 1'b1;
                                word_d   = 2'd0;
                                sdo_d    = prd1_q[31];
                            end else if (word_q == 2'd3) begin
                                state_d = DONE;
                                sdo_d   = 1'b0;
                            end else begin
                                word_d = word_q + 2'd1;
                                sdo_d  = nxt_word[31];
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            synced_q <= 1'b0;
            prd1_q   <= '0;
            prd2_q   <= '0;
            prd3_q   <= '0;
            ctrl_q   <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            half_q   <= '0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            synced_q <= synced_d;
            prd1_q   <= prd1_d;
            prd2_q   <= prd2_d;
            prd3_q   <= prd3_d;
            ctrl_q   <= ctrl_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            half_q   <= half_d;
            sck_q    <= sck_d;
            sdo_q    <= sdo_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SYNC) || (state_q == DATA);
    assign done  = (state_q == DONE);
    assign sck   = sck_q;
    assign sdo   = sdo_q;

endmodule

// File: tb/tb_spi_frame_transmitter.sv
// Directed bench: one transmitter at CLK_DIV=2 for the main frames, a second at CLK_DIV=1
// for the fast-clock timing checks; serial bits are captured on sck rising edges.
module tb_spi_frame_transmitter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid, valid2;
    logic [31:0] prd1, prd2, prd3;
    logic [1:0]  waveform, notes;
    logic        ready, busy, done, sck, sdo;
    logic        ready2, busy2, done2, sck2, sdo2;

    always #5 clk = ~clk;

    spi_frame_transmitter #(.CLK_DIV(2), .SYNC_WORD(32'h0000_FFFF)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid),
        .prd1(prd1), .prd2(prd2), .prd3(prd3), .waveform(waveform), .notes(notes),
        .ready(ready), .busy(busy), .done(done), .sck(sck), .sdo(sdo)
    );

    spi_frame_transmitter #(.CLK_DIV(1), .SYNC_WORD(32'h0000_FFFF)) dut2 (
        .clk(clk), .reset_n(reset_n), .valid(valid2),
        .prd1(prd1), .prd2(prd2), .prd3(prd3), .waveform(waveform), .notes(notes),
        .ready(ready2), .busy(busy2), .done(done2), .sck(sck2), .sdo(sdo2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter and sck-rise capture monitors
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [159:0] cap1 = '0, cap2 = '0;
    int rise1 = 0, rise2 = 0, done1 = 0, done2n = 0, viol2 = 0, per2 = 0, last_rise2 = 0;
    logic sck_p = 1'b0, sck2_p = 1'b0, sdo2_p = 1'b0, busy2_p = 1'b0;

    always @(negedge clk) begin
        if (sck && !sck_p) begin
            rise1 <= rise1 + 1;
            cap1  <= {cap1[158:0], sdo};
        end
        if (done) done1 <= done1 + 1;
        sck_p <= sck;
    end

    always @(negedge clk) begin
        if (sck2 && !sck2_p) begin
            rise2      <= rise2 + 1;
            cap2       <= {cap2[158:0], sdo2};
            last_rise2 <= cyc;
            if (rise2 > 0 && (cyc - last_rise2) != 2) per2 <= per2 + 1;
        end
        if (busy2_p && (sdo2 != sdo2_p) && !(sck2_p && !sck2)) viol2 <= viol2 + 1;
        if (done2) done2n <= done2n + 1;
        sck2_p  <= sck2;
        sdo2_p  <= sdo2;
        busy2_p <= busy2;
    end

    int t_acc, r_acc, d_acc, t_done;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [1:0] wf, input logic [1:0] nt, input bit hold);
        int n;
        n = 0;
        while (!ready && n < 2000) begin tick(); n++; end
        if (n >= 2000) chk("ready_wait", ready, 1'b1);
        prd1 = a; prd2 = b; prd3 = c; waveform = wf; notes = nt;
        valid = 1'b1;
        tick();
        t_acc = cyc; r_acc = rise1; d_acc = done1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 3000) begin tick(); n++; end
        chk("done_seen", done, 1'b1);
        t_done = cyc;
    endtask

    initial begin
        logic [31:0] cur_p1;
        logic [1:0]  cur_wf;
        int          bad, n;

        reset_n = 1'b0; valid = 1'b0; valid2 = 1'b0;
        prd1 = '0; prd2 = '0; prd3 = '0; waveform = '0; notes = '0;
        tick(); tick();
        chk("rst_outputs", {sck, sdo, ready, busy, done}, 5'b00100);
        reset_n = 1'b1;

        // Idle: no activity without valid
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (sck || sdo || busy || done || !ready) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_done", done1, 0);

        // First frame with sync word
        send(32'h0001_2345, 32'h0000_ABCD, 32'h0000_0F0F, 2'b11, 2'b11, 1'b0);
        chk("f1_busy", {busy, ready}, 2'b10);
        wait_done();
        chk("f1_latency", t_done - t_acc, 640);
        chk("f1_rises", rise1 - r_acc, 160);
        chk("f1_sync", cap1[159:128], 32'h0000_FFFF);
        chk("f1_prd1", cap1[127:96], 32'h0001_2345);
        chk("f1_prd2", cap1[95:64], 32'h0000_ABCD);
        chk("f1_prd3", cap1[63:32], 32'h0000_0F0F);
        chk("f1_ctrl", cap1[31:0], 32'h0000_000F);
        chk("f1_end_lines", {sck, sdo, busy}, 3'b000);
        tick();
        chk("f1_done_once", done1 - d_acc, 1);
        chk("f1_ready_back", ready, 1'b1);

        // Second frame, no sync word
        send(32'hDEAD_BEEF, 32'h0, 32'h0, 2'b01, 2'b01, 1'b0);
        wait_done();
        chk("f2_latency", t_done - t_acc, 512);
        chk("f2_rises", rise1 - r_acc, 128);
        chk("f2_prd1", cap1[127:96], 32'hDEAD_BEEF);
        chk("f2_prd2", cap1[95:64], 32'h0);
        chk("f2_prd3", cap1[63:32], 32'h0);
        chk("f2_ctrl", cap1[31:0], 32'h0000_0005);

        // valid held high, inputs toggled mid-frame
        send(32'h1234_5678, 32'h0BAD_F00D, 32'h0000_0777, 2'b10, 2'b10, 1'b1);
        bad = 0; n = 0;
        while (!done && n < 3000) begin
            if ((n % 37) == 5) begin prd1 = ~prd1; waveform = waveform + 2'd1; end
            if (ready) bad++;
            tick(); n++;
        end
        chk("f3_done_seen", done, 1'b1);
        chk("f3_ready_low", bad, 0);
        chk("f3_rises", rise1 - r_acc, 128);
        chk("f3_prd1", cap1[127:96], 32'h1234_5678);
        chk("f3_prd3", cap1[63:32], 32'h0000_0777);
        chk("f3_ctrl", cap1[31:0], 32'h0000_000A);
        cur_p1 = prd1; cur_wf = waveform;
        n = 0;
        while (!busy && n < 10) begin tick(); n++; end
        chk("f3_restart_gap", n, 2);
        t_acc = cyc - 1; r_acc = rise1;
        valid = 1'b0;
        wait_done();
        chk("f4_rises", rise1 - r_acc, 128);
        chk("f4_prd1", cap1[127:96], {32'h0, cur_p1});
        chk("f4_ctrl", cap1[31:0], {60'h0, 2'b10, cur_wf});

        // Reset in the middle of a frame
        send(32'hCAFE_0001, 32'h1, 32'h2, 2'b00, 2'b01, 1'b0);
        n = 0;
        while ((rise1 - r_acc) < 70 && n < 2000) begin tick(); n++; end
        chk("f5_bit70", rise1 - r_acc, 70);
        reset_n = 1'b0;
        #1;
        chk("f5_reset_outs", {sck, sdo, busy, ready, done}, 5'b00010);
        tick();
        reset_n = 1'b1;
        send(32'h0000_0042, 32'h0000_0043, 32'h0000_0044, 2'b10, 2'b11, 1'b0);
        wait_done();
        chk("f6_rises", rise1 - r_acc, 160);
        chk("f6_sync", cap1[159:128], 32'h0000_FFFF);
        chk("f6_prd1", cap1[127:96], 32'h0000_0042);
        chk("f6_ctrl", cap1[31:0], 32'h0000_000E);

        // CLK_DIV=1 instance
        prd1 = 32'h8000_0001; prd2 = 32'hAAAA_5555; prd3 = 32'h1234_5678;
        waveform = 2'b10; notes = 2'b10;
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        t_acc = cyc; r_acc = rise2;
        n = 0;
        while (!done2 && n < 2000) begin tick(); n++; end
        chk("d1_done_seen", done2, 1'b1);
        chk("d1_latency", cyc - t_acc, 320);
        chk("d1_rises", rise2 - r_acc, 160);
        chk("d1_sdo_on_fall", viol2, 0);
        chk("d1_sck_period", per2, 0);
        chk("d1_sync", cap2[159:128], 32'h0000_FFFF);
        chk("d1_prd1", cap2[127:96], 32'h8000_0001);
        chk("d1_prd2", cap2[95:64], 32'hAAAA_5555);
        chk("d1_prd3", cap2[63:32], 32'h1234_5678);
        chk("d1_ctrl", cap2[31:0], 32'h0000_000A);
        tick();
        chk("d1_done_once", done2n, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
